// File: rtl/cpu_sequencer_wb.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer owning the PC and register file.
// Define RETIRE_COUNT_EN to add the 32-bit `retired` instruction counter output.
module cpu_sequencer_wb #(
    parameter int          NREG     = 32,
    parameter logic [31:0] PC_RESET = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] ins_in,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  wra,
    input  logic [31:0] result,
    input  logic [31:0] nextpc,
    output logic [31:0] imem_addr,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic [31:0] reg1,
    output logic [31:0] reg2,
    output logic        mem_we_gate,
    output logic [2:0]  phase,
    output logic        halted
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0] retired
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= PC_RESET;
            ins   <= 32'd0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            state <= state_next;
            if (state == FETCH) begin
                ins <= ins_in;
            end
            if (state == WB) begin
                pc <= nextpc;
                if (wra != 5'd0) begin
                    regs[wra] <= result;
                end
            end
        end
    end

`ifdef RETIRE_COUNT_EN
    // Counts every committed instruction, the halting jump-to-self included.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= 32'd0;
        end else if (state == WB) begin
            retired <= retired + 32'd1;
        end
    end
`endif

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = run ? FETCH : IDLE;
            FETCH:   state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = (nextpc == pc) ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // r0 reads as zero regardless of array contents.
    assign reg1        = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign reg2        = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign imem_addr   = pc;
    assign mem_we_gate = (state == EXEC);
    assign halted      = (state == HALT);
    assign phase       = state;

endmodule
